// File: rtl/seq_101_tx.sv
// Serial "101"-sync frame transmitter: preamble 1,0,1, zero-stuffed MSB-first payload, zero guard run.
// One bit per clock on a registered d_out; a new word is accepted only from IDLE.
module seq_101_tx #(
  parameter int DATA_W    = 8,
  parameter int GUARD_LEN = 2
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              d_out,
  output logic              tx_active,
  output logic              stuff_bit
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = $clog2(GUARD_LEN + 1);

  typedef enum logic [1:0] {IDLE, PRE, DATA, GUARD} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic [BW-1:0]     bcnt, bcnt_nx;
  logic [GW-1:0]     gcnt, gcnt_nx;
  logic [1:0]        pcnt, pcnt_nx;
  logic [1:0]        hist, hist_nx;
  logic              d_nx, act_nx, stf_nx;

  assign tx_ready = (state == IDLE) && rst_n;

  // The first preamble bit goes out on the accept edge itself; PRE covers the remaining two.
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    bcnt_nx  = bcnt;
    gcnt_nx  = gcnt;
    pcnt_nx  = pcnt;
    d_nx     = 1'b0;
    act_nx   = 1'b0;
    stf_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          shreg_nx = tx_data;
          bcnt_nx  = BW'(DATA_W);
          pcnt_nx  = 2'd1;
          d_nx     = 1'b1;
          act_nx   = 1'b1;
          state_nx = PRE;
        end
      end
      PRE: begin
        act_nx  = 1'b1;
        d_nx    = (pcnt == 2'd2);
        pcnt_nx = pcnt + 2'd1;
        if (pcnt == 2'd2) state_nx = DATA;
      end
      DATA: begin
        act_nx = 1'b1;
        // A 1 after "10" would form the sync pattern, so insert a 0 first.
        if (hist == 2'b10) begin
          stf_nx = 1'b1;
        end else begin
          d_nx     = shreg[DATA_W-1];
          shreg_nx = shreg << 1;
          bcnt_nx  = bcnt - 1'b1;
          if (bcnt == BW'(1)) begin
            gcnt_nx  = '0;
            state_nx = GUARD;
          end
        end
      end
      GUARD: begin
        // One extra edge past the last guard zero returns the line to idle.
        if (gcnt == GW'(GUARD_LEN)) begin
          state_nx = IDLE;
        end else begin
          act_nx  = 1'b1;
          gcnt_nx = gcnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    hist_nx = {hist[0], d_nx};
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bcnt      <= '0;
      gcnt      <= '0;
      pcnt      <= '0;
      hist      <= 2'b00;
      d_out     <= 1'b0;
      tx_active <= 1'b0;
      stuff_bit <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      bcnt      <= bcnt_nx;
      gcnt      <= gcnt_nx;
      pcnt      <= pcnt_nx;
      hist      <= hist_nx;
      d_out     <= d_nx;
      tx_active <= act_nx;
      stuff_bit <= stf_nx;
    end
  end
endmodule

// File: tb/tb_seq_101_tx.sv
// Bench for seq_101_tx: per-frame bit/flag checks against a list-based frame model,
// plus a stream-level receiver that decodes every "101" frame of a long random run.
module tb_seq_101_tx;
  localparam int DW = 8;
  localparam int GL = 2;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_ready, d_out, tx_active, stuff_bit;

  int n_tests = 0;
  int n_fail  = 0;

  bit            exp_b[$];
  bit            exp_s[$];
  bit            stream[$];
  logic [DW-1:0] sent[$];
  bit            logging = 1'b0;

  always #5 clock = ~clock;

  seq_101_tx #(.DATA_W(DW), .GUARD_LEN(GL)) dut (
    .clock(clock), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .d_out(d_out), .tx_active(tx_active), .stuff_bit(stuff_bit)
  );

  always @(negedge clock) if (logging) stream.push_back(d_out);

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame as a list of emitted bits: a 0 is inserted whenever the last two emitted were 1,0.
  function automatic void build(input logic [DW-1:0] w);
    exp_b = {1'b1, 1'b0, 1'b1};
    exp_s = {1'b0, 1'b0, 1'b0};
    for (int i = DW - 1; i >= 0; i--) begin
      if (exp_b[exp_b.size()-2] == 1'b1 && exp_b[exp_b.size()-1] == 1'b0) begin
        exp_b.push_back(1'b0);
        exp_s.push_back(1'b1);
      end
      exp_b.push_back(w[i]);
      exp_s.push_back(1'b0);
    end
    repeat (GL) begin
      exp_b.push_back(1'b0);
      exp_s.push_back(1'b0);
    end
  endfunction

  // Called at a negedge; returns at the negedge of the idle cycle after the frame.
  task automatic send(input logic [DW-1:0] w, input bit hold, input int abort_at);
    int k;
    k = 0;
    while (!tx_ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("ready_wait", int'(tx_ready), 1);
    tx_data  = w;
    tx_valid = 1'b1;
    build(w);
    @(negedge clock);
    if (!hold) tx_valid = 1'b0;
    tx_data = DW'($urandom);
    for (int j = 0; j < exp_b.size(); j++) begin
      chk($sformatf("d_out[%0d] w=%0h", j, w), int'(d_out), int'(exp_b[j]));
      chk($sformatf("active[%0d]", j), int'(tx_active), 1);
      chk($sformatf("stuff[%0d] w=%0h", j, w), int'(stuff_bit), int'(exp_s[j]));
      chk($sformatf("ready_busy[%0d]", j), int'(tx_ready), 0);
      if (j == abort_at - 1) begin
        rst_n = 1'b0;
        @(negedge clock);
        chk("abort_d_out", int'(d_out), 0);
        chk("abort_active", int'(tx_active), 0);
        chk("abort_stuff", int'(stuff_bit), 0);
        chk("abort_ready", int'(tx_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_rel", int'(tx_ready), 1);
        return;
      end
      @(negedge clock);
    end
    chk("idle_d_out", int'(d_out), 0);
    chk("idle_active", int'(tx_active), 0);
    chk("idle_ready", int'(tx_ready), 1);
  endtask

  initial begin
    int            nwin, fi, p, got;
    bit            h1, h0;
    logic [DW-1:0] word;

    // Reset held with tx_valid asserted: nothing accepted, line quiet.
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    repeat (3) begin
      @(negedge clock);
      chk("rst_d_out", int'(d_out), 0);
      chk("rst_ready", int'(tx_ready), 0);
      chk("rst_active", int'(tx_active), 0);
      chk("rst_stuff", int'(stuff_bit), 0);
    end
    tx_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("rel_ready", int'(tx_ready), 1);
    @(negedge clock);
    chk("rel_d_out", int'(d_out), 0);

    send(8'hFF, 1'b0, 0);
    send(8'hAA, 1'b0, 0);
    send(8'h00, 1'b0, 0);
    send(8'h55, 1'b0, 0);
    send(8'h01, 1'b0, 0);
    send(8'h80, 1'b0, 0);
    send(8'hAA, 1'b0, 5);
    send(8'hAA, 1'b0, 0);

    // Long back-to-back run with tx_valid held high.
    logging = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      word = DW'($urandom);
      sent.push_back(word);
      send(word, 1'b1, 0);
    end
    tx_valid = 1'b0;
    @(negedge clock);
    logging = 1'b0;

    nwin = 0;
    fi   = 0;
    for (int i = 0; i + 2 < stream.size(); i++) begin
      if (stream[i] && !stream[i+1] && stream[i+2]) begin
        nwin++;
        p = i + 3; h1 = 1'b0; h0 = 1'b1; got = 0; word = '0;
        while (got < DW && p < stream.size()) begin
          if (!(h1 && !h0)) begin
            word = {word[DW-2:0], stream[p]};
            got++;
          end
          h1 = h0;
          h0 = stream[p];
          p++;
        end
        if (fi < sent.size()) chk($sformatf("rx_word[%0d]", fi), int'(word), int'(sent[fi]));
        fi++;
      end
    end
    chk("rx_frames", nwin, sent.size());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
